// File: rtl/nf10_rr_input_arbiter_if.sv
// Bundle of NUM_LANES parallel AXI4-Stream lanes; lane i occupies [i*W +: W] of each packed field.
// The master modport drives the payload, and the slave modport drives tready back.
interface nf10_rr_input_arbiter_if #(
  parameter int NUM_LANES   = 1,
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
);
  logic [NUM_LANES*DATA_WIDTH-1:0]   tdata;
  logic [NUM_LANES*DATA_WIDTH/8-1:0] tstrb;
  logic [NUM_LANES*TUSER_WIDTH-1:0]  tuser;
  logic [NUM_LANES-1:0]              tvalid;
  logic [NUM_LANES-1:0]              tlast;
  logic [NUM_LANES-1:0]              tready;

  modport master (output tdata, output tstrb, output tuser, output tvalid, output tlast,
                  input tready);
  modport slave  (input tdata, input tstrb, input tuser, input tvalid, input tlast,
                  output tready);
endinterface

// File: rtl/nf10_rr_input_arbiter.sv
// Packet-granular round-robin arbiter: one RX stream at a time owns the shared datapath
// from grant until its tlast handshake, with a zero-latency combinational data mux.
module nf10_rr_input_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int C_DATA_WIDTH  = 256,
  parameter int C_TUSER_WIDTH = 128,
  localparam int GW           = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                   axi_aclk,
  input  logic                   axi_reset,
  nf10_rr_input_arbiter_if.slave  s_axis,
  nf10_rr_input_arbiter_if.master m_axis,
  input  logic [NUM_PORTS-1:0]   port_en,
  output logic [GW-1:0]          cur_grant,
  output logic                   pkt_active
);
  localparam int SW = C_DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [GW-1:0]        grant_r;
  logic [GW-1:0]        grant_s;
  logic [GW-1:0]        last_grant_r;
  logic [GW-1:0]        last_grant_s;
  logic [GW-1:0]        pick_s;
  logic [NUM_PORTS-1:0] req_s;
  logic [NUM_PORTS-1:0] ready_s;
  logic                 m_valid_s;
  logic                 beat_s;

  // Scan last+N down to last+1 so the nearest requester after last_grant is what remains.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                            input logic [GW-1:0] last);
    logic [GW-1:0] win;
    int            idx;
    win = last;
    for (int off = NUM_PORTS; off >= 1; off--) begin
      idx = (int'(last) + off) % NUM_PORTS;
      if (req[idx]) begin
        win = GW'(idx);
      end
    end
    return win;
  endfunction

  assign req_s  = s_axis.tvalid & port_en;
  assign pick_s = rr_pick(req_s, last_grant_r);
  assign beat_s = s_axis.tvalid[grant_r] & m_axis.tready[0];

  // Next-state, grant selection and handshake steering.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    ready_s      = {NUM_PORTS{1'b0}};
    m_valid_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|req_s) begin
          grant_s      = pick_s;
          last_grant_s = pick_s;
          state_s      = ST_PKT;
        end else begin
          state_s      = ST_IDLE;
        end
      end
      ST_PKT: begin
        m_valid_s        = s_axis.tvalid[grant_r];
        ready_s[grant_r] = m_axis.tready[0];
        if (beat_s && s_axis.tlast[grant_r]) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_PKT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Arbitration state; reset leaves last_grant on the top port so port 0 wins first.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_r      <= ST_IDLE;
      grant_r      <= {GW{1'b0}};
      last_grant_r <= GW'(NUM_PORTS - 1);
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
    end
  end

  assign s_axis.tready = ready_s;
  assign m_axis.tvalid = m_valid_s;
  assign m_axis.tdata  = s_axis.tdata[grant_r*C_DATA_WIDTH +: C_DATA_WIDTH];
  assign m_axis.tstrb  = s_axis.tstrb[grant_r*SW +: SW];
  assign m_axis.tuser  = s_axis.tuser[grant_r*C_TUSER_WIDTH +: C_TUSER_WIDTH];
  assign m_axis.tlast  = s_axis.tlast[grant_r];
  assign cur_grant     = grant_r;
  assign pkt_active    = (state_r == ST_PKT);
endmodule

// File: tb/tb_nf10_rr_input_arbiter.sv
// Bench for nf10_rr_input_arbiter: per-port source queues feed the slave lanes, and a scoreboard
// of expected beats in grant order is compared against every master-side handshake.
module tb_nf10_rr_input_arbiter;
  localparam int NP = 4;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int SW = DW / 8;

  logic          axi_aclk = 1'b0;
  logic          axi_reset;
  logic [NP-1:0] port_en;
  logic [1:0]    cur_grant;
  logic          pkt_active;

  nf10_rr_input_arbiter_if #(.NUM_LANES(NP), .DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_if ();
  nf10_rr_input_arbiter_if #(.NUM_LANES(1),  .DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_if ();

  nf10_rr_input_arbiter #(.NUM_PORTS(NP), .C_DATA_WIDTH(DW), .C_TUSER_WIDTH(UW)) dut (
    .axi_aclk   (axi_aclk),
    .axi_reset  (axi_reset),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .port_en    (port_en),
    .cur_grant  (cur_grant),
    .pkt_active (pkt_active)
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct {
    int          port;
    logic [31:0] w;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic           rst;
    logic [3:0]     en;
    logic [3:0][3:0] len;
    logic [3:0][1:0] npk;
    logic [3:0]     n;
    logic [7:0][1:0] exp;
  } row_t;

  beat_t         srcq[$];
  beat_t         expq[$];
  int            glog[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            out_cnt = 0;
  int            first_act;
  int            last_act;
  logic [NP-1:0] hs = '0;
  logic [NP-1:0] pause = '0;
  logic          mready = 1'b1;
  logic          prev_act = 1'b0;
  logic          smp_act;
  logic          smp_mvalid;
  logic [1:0]    smp_grant;
  logic [NP-1:0] smp_sready;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int find(input int p);
    foreach (srcq[i]) begin
      if (srcq[i].port == p) return i;
    end
    return -1;
  endfunction

  function automatic row_t mkrow(input logic rs, input logic [3:0] en, input logic [15:0] len,
                                 input logic [7:0] npk, input logic [3:0] n,
                                 input logic [15:0] ex);
    row_t r;
    r.rst = rs; r.en = en; r.len = len; r.npk = npk; r.n = n; r.exp = ex;
    return r;
  endfunction

  task automatic add_pkt(input int tag, input int p, input int pk, input int nb, input bit expect_out);
    beat_t x;
    for (int b = 0; b < nb; b++) begin
      x.port = p;
      x.w    = {8'(tag), 8'(p), 8'(pk), 8'(b)};
      x.last = (b == nb - 1);
      srcq.push_back(x);
      if (expect_out) expq.push_back(x);
    end
  endtask

  task automatic apply();
    logic [NP*DW-1:0] d;
    logic [NP*SW-1:0] st;
    logic [NP*UW-1:0] u;
    logic [NP-1:0]    v;
    logic [NP-1:0]    l;
    int               idx;
    for (int p = 0; p < NP; p++) begin
      if (hs[p]) begin
        idx = find(p);
        if (idx >= 0) srcq.delete(idx);
      end
    end
    hs = '0;
    d = '0; st = '0; u = '0; v = '0; l = '0;
    for (int p = 0; p < NP; p++) begin
      idx = find(p);
      if (idx >= 0) begin
        v[p]            = !pause[p];
        l[p]            = srcq[idx].last;
        d[p*DW +: DW]   = {8{srcq[idx].w}};
        u[p*UW +: UW]   = {4{~srcq[idx].w}};
        st[p*SW +: SW]  = srcq[idx].w;
      end
    end
    s_if.tdata  = d;
    s_if.tstrb  = st;
    s_if.tuser  = u;
    s_if.tvalid = v;
    s_if.tlast  = l;
    m_if.tready = mready;
  endtask

  task automatic sample();
    beat_t         e;
    logic [NP-1:0] exp_rdy;
    cyc++;
    hs         = s_if.tvalid & s_if.tready;
    smp_act    = pkt_active;
    smp_mvalid = m_if.tvalid[0];
    smp_grant  = cur_grant;
    smp_sready = s_if.tready;
    if (!axi_reset) begin
      exp_rdy = pkt_active ? (NP'(m_if.tready[0]) << cur_grant) : '0;
      chk("sready_rule", s_if.tready, exp_rdy);
      chk("mvalid_rule", m_if.tvalid[0], pkt_active & s_if.tvalid[cur_grant]);
    end
    if (m_if.tvalid[0] && m_if.tready[0]) begin
      out_cnt++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h expected none", m_if.tdata[31:0]);
      end else begin
        e = expq.pop_front();
        chk("beat_data", m_if.tdata, {8{e.w}});
        chk("beat_user", m_if.tuser, {4{~e.w}});
        chk("beat_strb", m_if.tstrb, e.w);
        chk("beat_last", m_if.tlast[0], e.last);
        chk("beat_port", cur_grant, e.port);
      end
    end
    if (pkt_active && !prev_act) glog.push_back(int'(cur_grant));
    if (pkt_active) begin
      if (first_act < 0) first_act = cyc;
      last_act = cyc;
    end
    prev_act = pkt_active;
  endtask

  task automatic tick();
    @(negedge axi_aclk);
    sample();
    @(posedge axi_aclk);
    #1;
    apply();
  endtask

  task automatic begin_window();
    glog.delete();
    first_act = -1;
    last_act  = -1;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (expq.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    chk("drain_left", expq.size(), 0);
    tick();
    tick();
  endtask

  task automatic rst_assert();
    axi_reset = 1'b1;
    srcq.delete();
    expq.delete();
    hs       = '0;
    pause    = '0;
    prev_act = 1'b0;
    apply();
    #1;
    chk("rst_mvalid", m_if.tvalid[0], 1'b0);
    chk("rst_sready", s_if.tready, 4'b0000);
    chk("rst_active", pkt_active, 1'b0);
    chk("rst_grant",  cur_grant, 2'd0);
  endtask

  task automatic rst_release();
    @(posedge axi_aclk);
    #1;
    axi_reset = 1'b0;
  endtask

  task automatic run_row(input row_t r, input int tag);
    int cnt[NP];
    int beats;
    int p;
    if (r.rst) rst_assert();
    cnt   = '{default: 0};
    beats = 0;
    for (int k = 0; k < int'(r.n); k++) begin
      p = int'(r.exp[k]);
      add_pkt(tag, p, cnt[p], int'(r.len[p]), 1'b1);
      cnt[p]++;
      beats += int'(r.len[p]);
    end
    for (int q = 0; q < NP; q++) begin
      while (cnt[q] < int'(r.npk[q])) begin
        add_pkt(tag, q, cnt[q], int'(r.len[q]), 1'b0);
        cnt[q]++;
      end
    end
    port_en = r.en;
    apply();
    if (r.rst) rst_release();
    begin_window();
    drain(200);
    tick();
    tick();
    chk($sformatf("row%0d_grant_count", tag), glog.size(), r.n);
    for (int k = 0; k < glog.size() && k < int'(r.n); k++) begin
      chk($sformatf("row%0d_grant%0d", tag, k), glog[k], r.exp[k]);
    end
    if (r.n != 4'd0) chk($sformatf("row%0d_span", tag), last_act - first_act + 1, beats + int'(r.n) - 1);
    srcq.delete();
    apply();
    tick();
  endtask

  row_t rows[8];
  int   base;
  int   n;

  initial begin
    port_en = '1;
    mready  = 1'b1;

    // Reset release, port 2 sends a 3-beat packet: bubble, three beats, then IDLE.
    rst_assert();
    add_pkt(100, 2, 0, 3, 1'b1);
    apply();
    rst_release();
    begin_window();
    base = out_cnt;
    tick();
    chk("t1_idle_c1", smp_act, 1'b0);
    chk("t1_mvalid_c1", smp_mvalid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_pkt_active", smp_act, 1'b1);
      chk("t1_grant", smp_grant, 2'd2);
      chk("t1_beats", out_cnt - base, i + 1);
    end
    tick();
    chk("t1_idle_c5", smp_act, 1'b0);
    drain(10);

    rows[0] = mkrow(1'b1, 4'b1111, 16'h1111, 8'h5A, 4'd6, 16'h04E4);
    rows[1] = mkrow(1'b0, 4'b1111, 16'h0202, 8'h11, 4'd2, 16'h0002);
    rows[2] = mkrow(1'b0, 4'b1111, 16'h1000, 8'h40, 4'd1, 16'h0003);
    rows[3] = mkrow(1'b0, 4'b1111, 16'h0303, 8'h11, 4'd2, 16'h0008);
    rows[4] = mkrow(1'b0, 4'b1111, 16'h0020, 8'h0C, 4'd3, 16'h0015);
    rows[5] = mkrow(1'b0, 4'b1010, 16'h1111, 8'h55, 4'd2, 16'h0007);
    rows[6] = mkrow(1'b0, 4'b0000, 16'h1111, 8'h55, 4'd0, 16'h0000);
    rows[7] = mkrow(1'b0, 4'b1111, 16'h1101, 8'h51, 4'd3, 16'h000E);
    for (int r = 0; r < 8; r++) run_row(rows[r], r);

    // Port 1 loses port_en after beat 2: packet finishes, next grant skips port 1.
    port_en = '1;
    rst_assert();
    add_pkt(30, 1, 0, 4, 1'b1);
    add_pkt(30, 2, 0, 1, 1'b1);
    add_pkt(30, 1, 1, 2, 1'b0);
    apply();
    rst_release();
    begin_window();
    base = out_cnt;
    n = 0;
    while (out_cnt - base < 2 && n < 20) begin
      tick();
      n++;
    end
    port_en = 4'b1101;
    drain(50);
    chk("t3_grant_count", glog.size(), 2);
    if (glog.size() > 1) begin
      chk("t3_grant0", glog[0], 1);
      chk("t3_grant1", glog[1], 2);
    end
    srcq.delete();
    port_en = '1;
    apply();
    tick();

    // Port 3 packet under tready 1,0,0,1 and a source valid gap, port 0 waiting.
    rst_assert();
    add_pkt(40, 3, 0, 3, 1'b1);
    apply();
    rst_release();
    begin_window();
    base = out_cnt;
    tick();
    chk("t4_idle", smp_act, 1'b0);
    tick();
    chk("t4_b0", out_cnt - base, 1);
    chk("t4_grant", smp_grant, 2'd3);
    add_pkt(40, 0, 0, 1, 1'b1);
    mready = 1'b0;
    apply();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t4_stall_cnt", out_cnt - base, 1);
      chk("t4_stall_mvalid", smp_mvalid, 1'b1);
      chk("t4_stall_sready", smp_sready, 4'b0000);
    end
    mready = 1'b1;
    apply();
    tick();
    chk("t4_b1", out_cnt - base, 2);
    chk("t4_sready", smp_sready, 4'b1000);
    pause[3] = 1'b1;
    apply();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t4_gap_mvalid", smp_mvalid, 1'b0);
      chk("t4_gap_grant", smp_grant, 2'd3);
      chk("t4_gap_active", smp_act, 1'b1);
    end
    pause = '0;
    apply();
    tick();
    chk("t4_b2", out_cnt - base, 3);
    drain(20);
    chk("t4_grant_count", glog.size(), 2);
    if (glog.size() > 1) begin
      chk("t4_grant0", glog[0], 3);
      chk("t4_grant1", glog[1], 0);
    end

    // Reset during beat 2 of 5: outputs drop at once, port 0 has priority again.
    rst_assert();
    add_pkt(60, 0, 0, 5, 1'b1);
    apply();
    rst_release();
    base = out_cnt;
    n = 0;
    while (out_cnt - base < 1 && n < 20) begin
      tick();
      n++;
    end
    #2;
    rst_assert();
    add_pkt(61, 0, 0, 1, 1'b1);
    add_pkt(61, 2, 0, 1, 1'b1);
    apply();
    rst_release();
    begin_window();
    drain(30);
    chk("t6_grant_count", glog.size(), 2);
    if (glog.size() > 1) begin
      chk("t6_grant0", glog[0], 0);
      chk("t6_grant1", glog[1], 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
